uart_rx_fifo: RTL and testbench
===============================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DATA_BITS, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter OVERSAMPLE, default 16, baud_clk cycles per bit (even, legal 8..32).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, >=2).
REQ-004 SHALL have parameter RTS_MARGIN, default 1, free entries at which rts drops (1..FIFO_DEPTH-1).
REQ-005 SHALL have parameter PARITY_ODD, default 0, parity sense: 0 = even, 1 = odd.
REQ-006 baud_clk  in  1  sole clock, running at OVERSAMPLE x bit rate.
REQ-007 rst  in  1  synchronous active-high reset, sampled on the baud_clk rising edge.
REQ-008 rx  in  1  asynchronous serial line, idle high, LSB first.
REQ-009 rd_en  in  1  pop request for the FIFO head.
REQ-010 clr_err  in  1  one-cycle pulse that clears overrun.
REQ-011 rd_data  out  DATA_BITS  FIFO head word; zero when empty.
REQ-012 data_valid  out  1  FIFO non-empty.
REQ-013 rx_buffer_empty  out  1  FIFO empty; always equals ~data_valid.
REQ-014 fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
REQ-015 rts  out  1  high while fifo_count < FIFO_DEPTH-RTS_MARGIN.
REQ-016 frame_err, parity_err  out  1 each  one-cycle error pulses.
REQ-017 overrun  out  1  sticky; set when a good word arrives with the FIFO full.

Function
REQ-018 rx SHALL pass through a 2-flop synchronizer (flops reset to 1); all decisions use the synchronized value rx_s.
REQ-019 FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
REQ-020 IDLE: rx_s==0 -> START with tick counter cleared.
REQ-021 START: after OVERSAMPLE/2 cycles, sample rx_s; 0 -> DATA, 1 -> IDLE as a false start with no flag and no push.
REQ-022 DATA: sample every OVERSAMPLE cycles; shift LSB first; after DATA_BITS samples -> PARITY if compiled in, else STOP.
REQ-023 STOP: sample after OVERSAMPLE cycles; rx_s==1 -> push the word (if no parity error) -> IDLE; rx_s==0 -> frame_err pulse, word dropped -> WAIT_IDLE.
REQ-024 WAIT_IDLE SHALL hold until rx_s==1 and then enter IDLE (break handling).
REQ-025 A pushed word SHALL be visible on rd_data/data_valid and in fifo_count the cycle after the stop sample.
REQ-026 FIFO SHALL be first-word fall-through; rd_en with data_valid pops in one cycle; rd_en while empty SHALL be ignored.
REQ-027 Push while full without a simultaneous pop: word dropped, overrun set; push and pop in the same cycle while full: both occur, count unchanged, overrun not set.
REQ-028 Pointers SHALL wrap modulo FIFO_DEPTH; fifo_count SHALL never exceed FIFO_DEPTH or underflow.
REQ-029 overrun SHALL clear on clr_err; if clr_err and a new overrun coincide, set wins.
REQ-030 Error pulses SHALL be exactly one cycle wide and aligned with the stop (or parity) sample cycle plus one.

Reset
REQ-031 rst SHALL force: FSM=IDLE, counters=0, FIFO empty, rd_data=0, data_valid=0, rx_buffer_empty=1, fifo_count=0, rts=1, frame_err=parity_err=overrun=0.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; the next falling edge after release SHALL be treated as a fresh start bit.

Configuration
REQ-033 Macro UART_RX_PARITY_EN defined: a PARITY state follows DATA, samples one bit, and checks it against PARITY_ODD; on mismatch parity_err pulses and the word is dropped; the STOP check still applies.
REQ-034 Macro UART_RX_PARITY_EN undefined: no PARITY state; frames are 8N1-style; parity_err is tied 0 and PARITY_ODD is ignored.

Verification (DATA_BITS=8, OVERSAMPLE=16, FIFO_DEPTH=4, RTS_MARGIN=1)
REQ-035 Frame 0xA5 with valid stop -> data_valid=1, rd_data=0xA5, fifo_count=1; one rd_en -> empty.
REQ-036 rx low for 4 cycles, then high -> no push, no error, FSM back in IDLE.
REQ-037 Frame 0x3C with stop=0, rx held low for 40 cycles -> frame_err single pulse, fifo_count=0, no start detected until rx returns high.
REQ-038 Frames 0x01..0x05 with no pops -> rts low at count 3, count=4, overrun=1 after 5th; pops return 01,02,03,04; clr_err clears overrun.
REQ-039 UART_RX_PARITY_EN, even parity: 0x07 with parity bit 0 -> parity_err pulse, no push; 0x07 with parity bit 1 -> push 0x07.
REQ-040 rst pulsed after 3 data bits of 0xFF -> all outputs at reset values; next frame 0x5A received intact.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver with synchronizer, oversampled framing FSM and a first-word fall-through receive FIFO.
// Optional parity stage is compiled in when UART_RX_PARITY_EN is defined.
module uart_rx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int RTS_MARGIN = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                          baud_clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          data_valid,
  output logic                          rx_buffer_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          rts,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] DATA      = 3'd2;
  localparam logic [2:0] PARITY    = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;
  localparam logic [2:0] WAIT_IDLE = 3'd5;

  logic                 rx_meta;
  logic                 rx_s;
  logic [2:0]           state;
  logic [TW-1:0]        tick;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bad;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 wr;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        IDLE: begin
          tick <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (tick == HALF_LAST) begin
            tick    <= '0;
            bit_cnt <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            tick <= tick + 1'b1;
          end
        end
        DATA: begin
          if (tick == FULL_LAST) begin
            tick  <= '0;
            shift <= {rx_s, shift[DATA_BITS-1:1]};
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick == FULL_LAST) begin
            tick  <= '0;
            state <= STOP;
          end else begin
            tick <= tick + 1'b1;
          end
        end
`endif
        STOP: begin
          if (tick == FULL_LAST) begin
            tick <= '0;
            if (rx_s) begin
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_IDLE;
            end
          end else begin
            tick <= tick + 1'b1;
          end
        end
        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity verdict is latched at the parity sample and consulted at the stop sample.
  always_ff @(posedge baud_clk) begin
    if (rst) begin
      parity_bad <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      if (state == PARITY && tick == FULL_LAST) begin
        parity_bad <= (rx_s != ((^shift) ^ (PARITY_ODD != 0)));
        parity_err <= (rx_s != ((^shift) ^ (PARITY_ODD != 0)));
      end
    end
  end
`else
  logic unused_parity_odd;
  assign unused_parity_odd = (PARITY_ODD != 0);
  assign parity_bad        = 1'b0;
  assign parity_err        = 1'b0;
`endif

  assign push = (state == STOP) && (tick == FULL_LAST) && rx_s && !parity_bad;
  assign pop  = rd_en && data_valid;
  assign full = (fifo_count == CW'(FIFO_DEPTH));
  assign wr   = push && (!full || pop);

  always_ff @(posedge baud_clk) begin
    if (wr) mem[wr_ptr] <= shift;
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overrun    <= 1'b0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A new overrun takes priority over a clear in the same cycle.
      if (push && full && !pop) overrun <= 1'b1;
      else if (clr_err)         overrun <= 1'b0;
    end
  end

  assign data_valid      = (fifo_count != '0);
  assign rx_buffer_empty = !data_valid;
  assign rd_data         = data_valid ? mem[rd_ptr] : '0;
  assign rts             = (fifo_count < CW'(FIFO_DEPTH - RTS_MARGIN));

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus pushes expected words, a monitor pops and compares on each read.
// Exercises the parity path as well when UART_RX_PARITY_EN is defined.
module tb_uart_rx_fifo;

  localparam int DB = 8;
  localparam int OS = 16;
  localparam int FD = 4;
  localparam int RM = 1;

  logic          baud_clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          rd_en;
  logic          clr_err;
  logic [DB-1:0] rd_data;
  logic          data_valid;
  logic          rx_buffer_empty;
  logic [2:0]    fifo_count;
  logic          rts;
  logic          frame_err;
  logic          parity_err;
  logic          overrun;

  int        checks = 0;
  int        failures = 0;
  logic [7:0] exp_q[$];
  bit        exp_overrun = 1'b0;
  int        exp_fe = 0;
  int        exp_pe = 0;
  int        fe_seen = 0;
  int        pe_seen = 0;
  logic      fe_d = 1'b0;
  logic      pe_d = 1'b0;

  uart_rx_fifo #(
    .DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(FD), .RTS_MARGIN(RM), .PARITY_ODD(0)
  ) dut (
    .baud_clk(baud_clk), .rst(rst), .rx(rx), .rd_en(rd_en), .clr_err(clr_err),
    .rd_data(rd_data), .data_valid(data_valid), .rx_buffer_empty(rx_buffer_empty),
    .fifo_count(fifo_count), .rts(rts), .frame_err(frame_err),
    .parity_err(parity_err), .overrun(overrun)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge baud_clk);
    #1;
  endtask

  // Monitor: compares the FIFO head whenever a read is presented, and checks error pulse widths.
  always @(negedge baud_clk) begin
    if (!rst && rd_en) begin
      checks++;
      if (exp_q.size() > 0) begin
        if (!data_valid || rd_data !== exp_q[0]) begin
          failures++;
          $display("[TB] FAIL pop_data: got valid=%0b data=%0h expected %0h", data_valid, rd_data, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end else if (data_valid) begin
        failures++;
        $display("[TB] FAIL pop_empty: got valid=1 data=%0h expected empty", rd_data);
      end
    end
    if (frame_err) begin
      fe_seen++;
      checks++;
      if (fe_d) begin
        failures++;
        $display("[TB] FAIL frame_err_width: got >1 cycle expected 1 cycle");
      end
    end
    if (parity_err) begin
      pe_seen++;
      checks++;
      if (pe_d) begin
        failures++;
        $display("[TB] FAIL parity_err_width: got >1 cycle expected 1 cycle");
      end
    end
    fe_d = frame_err;
    pe_d = parity_err;
  end

  // Drives one frame; good_par selects correct or inverted parity in the parity build.
  task automatic applyStimulus(input logic [7:0] d, input logic stop_bit, input logic good_par, input int low_tail);
    rx = 1'b0;
    cycles(OS);
    for (int i = 0; i < DB; i++) begin
      rx = d[i];
      cycles(OS);
    end
`ifdef UART_RX_PARITY_EN
    rx = good_par ? (^d) : ~(^d);
    cycles(OS);
`else
    if (!good_par) $display("[TB] note: parity ignored in this build");
`endif
    rx = stop_bit;
    cycles(OS);
    if (low_tail > 0) cycles(low_tail);
    rx = 1'b1;
    cycles(4);
  endtask

  // Reference model: what the receiver should do with a frame under the stated line conditions.
  task automatic expectFrame(input logic [7:0] d, input bit stop_ok, input bit par_ok);
`ifdef UART_RX_PARITY_EN
    if (!par_ok) exp_pe++;
`endif
    if (!stop_ok) exp_fe++;
`ifdef UART_RX_PARITY_EN
    if (stop_ok && par_ok) begin
`else
    if (stop_ok) begin
`endif
      if (exp_q.size() < FD) exp_q.push_back(d);
      else exp_overrun = 1'b1;
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input int low_tail);
    expectFrame(d, stop_ok, par_ok);
    applyStimulus(d, stop_ok, par_ok, low_tail);
  endtask

  task automatic popOne();
    rd_en = 1'b1;
    cycles(1);
    rd_en = 1'b0;
    cycles(1);
  endtask

  task automatic checkState(input string tag);
    int n;
    n = exp_q.size();
    checkOutput({tag, "_count"}, 32'(fifo_count), 32'(n));
    checkOutput({tag, "_valid"}, 32'(data_valid), 32'(n > 0));
    checkOutput({tag, "_empty"}, 32'(rx_buffer_empty), 32'(n == 0));
    checkOutput({tag, "_rts"}, 32'(rts), 32'(n < FD - RM));
    checkOutput({tag, "_overrun"}, 32'(overrun), 32'(exp_overrun));
    checkOutput({tag, "_head"}, 32'(rd_data), (n > 0) ? 32'(exp_q[0]) : 32'd0);
    checkOutput({tag, "_fe_pulses"}, 32'(fe_seen), 32'(exp_fe));
    checkOutput({tag, "_pe_pulses"}, 32'(pe_seen), 32'(exp_pe));
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_count"}, 32'(fifo_count), 32'd0);
    checkOutput({tag, "_valid"}, 32'(data_valid), 32'd0);
    checkOutput({tag, "_empty"}, 32'(rx_buffer_empty), 32'd1);
    checkOutput({tag, "_rts"}, 32'(rts), 32'd1);
    checkOutput({tag, "_data"}, 32'(rd_data), 32'd0);
    checkOutput({tag, "_flags"}, {29'd0, frame_err, parity_err, overrun}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] d;
    bit         sok;
    bit         pok;
    rst = 1'b1; rx = 1'b1; rd_en = 1'b0; clr_err = 1'b0;
    cycles(3);
    checkReset("reset");
    rst = 1'b0;
    cycles(5);

    $display("[TB] single frame 0xA5");
    sendFrame(8'hA5, 1'b1, 1'b1, 0);
    checkState("a5");
    popOne();
    checkState("a5_popped");
    popOne();
    checkState("pop_when_empty");

    $display("[TB] false start");
    rx = 1'b0;
    cycles(4);
    rx = 1'b1;
    cycles(40);
    checkState("false_start");

    $display("[TB] framing error with break");
    sendFrame(8'h3C, 1'b0, 1'b1, 40);
    cycles(200);
    checkState("frame_err");
    sendFrame(8'h11, 1'b1, 1'b1, 0);
    checkState("after_break");
    popOne();

    $display("[TB] fill and overrun");
    for (int i = 1; i <= 5; i++) begin
      sendFrame(8'(i), 1'b1, 1'b1, 0);
      checkState($sformatf("fill%0d", i));
    end
    for (int i = 0; i < 4; i++) popOne();
    checkState("drained");
    clr_err = 1'b1;
    cycles(1);
    clr_err = 1'b0;
    exp_overrun = 1'b0;
    cycles(1);
    checkState("cleared");

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity checks");
    sendFrame(8'h07, 1'b1, 1'b0, 0);
    checkState("par_bad");
    sendFrame(8'h07, 1'b1, 1'b1, 0);
    checkState("par_good");
    popOne();
`endif

    $display("[TB] reset mid-frame");
    rx = 1'b0;
    cycles(OS);
    rx = 1'b1;
    cycles(3 * OS);
    rst = 1'b1;
    cycles(2);
    exp_q.delete();
    exp_overrun = 1'b0;
    checkReset("mid_reset");
    rst = 1'b0;
    cycles(20);
    sendFrame(8'h5A, 1'b1, 1'b1, 0);
    checkState("after_reset");
    popOne();

    $display("[TB] randomized frames");
    for (int k = 0; k < 24; k++) begin
      d   = 8'($urandom_range(0, 255));
      sok = ($urandom_range(0, 4) != 0);
`ifdef UART_RX_PARITY_EN
      pok = ($urandom_range(0, 4) != 0);
`else
      pok = 1'b1;
`endif
      sendFrame(d, sok, pok, sok ? 0 : 20);
      checkState($sformatf("rand%0d", k));
      if ($urandom_range(0, 2) == 0 && exp_q.size() > 0) popOne();
      if (exp_overrun && $urandom_range(0, 1) == 1) begin
        clr_err = 1'b1;
        cycles(1);
        clr_err = 1'b0;
        exp_overrun = 1'b0;
        cycles(1);
      end
    end
    while (exp_q.size() > 0) popOne();
    checkState("final");

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
